// File: rtl/idli_sx_m.sv
// idli_sx_m: bit-slice serial execute unit.
// One instruction is accepted per word window (at the last beat) and executed
// LSB-slice-first over BEATS cycles. Result slices are shifted into a shadow
// register and the whole word is committed to the register file on the edge
// that ends the window, so a flush anywhere in the window cancels it cleanly.
module idli_sx_m #(
  parameter  int SLICE_W = 4,
  parameter  int WORD_W  = 16,
  parameter  int NREG    = 16,
  localparam int BEATS   = WORD_W / SLICE_W,
  localparam int CW      = $clog2(BEATS),
  localparam int RW      = $clog2(NREG)
) (
  input  logic               i_sx_gck,
  input  logic               i_sx_rst,
  input  logic               i_sx_vld,
  input  logic [2:0]         i_sx_op,
  input  logic [RW-1:0]      i_sx_dst,
  input  logic [RW-1:0]      i_sx_lhs,
  input  logic [RW-1:0]      i_sx_rhs,
  input  logic               i_sx_imm_en,
  input  logic [WORD_W-1:0]  i_sx_imm,
  input  logic               i_sx_flush,
  output logic [CW-1:0]      o_sx_ctr,
  output logic               o_sx_busy,
  output logic [SLICE_W-1:0] o_sx_res,
  output logic               o_sx_res_vld,
  output logic               o_sx_done,
  output logic               o_sx_z,
  output logic               o_sx_c
);

  // Shadow holds the slices already produced in this window; the current
  // slice is concatenated on top to form the full word at the last beat.
  localparam int SHW = WORD_W - SLICE_W;

  localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
  localparam logic [CW-1:0] FIRST_BEAT = {CW{1'b0}};
  localparam logic [RW-1:0] R0         = {RW{1'b0}};

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;

  // Extract slice k of a word, bits [k*SLICE_W +: SLICE_W].
  function automatic logic [SLICE_W-1:0] slice_of(input logic [WORD_W-1:0] w,
                                                  input logic [CW-1:0]     k);
    logic [WORD_W-1:0] sh;
    sh = w >> (int'(k) * SLICE_W);
    return sh[SLICE_W-1:0];
  endfunction

  // Control / flag state
  logic [CW-1:0]      ctr_q,    ctr_d;
  logic               busy_q,   busy_d;
  logic               cancel_q, cancel_d;
  logic               carry_q,  carry_d;
  logic [SHW-1:0]     shadow_q, shadow_d;
  logic               done_q,   done_d;
  logic               z_q,      z_d;
  logic               c_q,      c_d;

  // Latched instruction fields
  logic [2:0]         op_q;
  logic [RW-1:0]      dst_q;
  logic [RW-1:0]      lhs_q;
  logic [RW-1:0]      rhs_q;
  logic               imm_en_q;
  logic [WORD_W-1:0]  imm_q;

  // Register file; entry 0 is held at zero and never written after reset
  logic [WORD_W-1:0]  rf_q [NREG];

  // Datapath
  logic [WORD_W-1:0]  lhs_word_s;
  logic [WORD_W-1:0]  rhs_word_s;
  logic [SLICE_W-1:0] a_s;
  logic [SLICE_W-1:0] b_s;
  logic [SLICE_W-1:0] b_add_s;
  logic               is_sub_s;
  logic               is_arith_s;
  logic               op_valid_s;
  logic               cin_s;
  logic [SLICE_W:0]   sum_s;
  logic [SLICE_W-1:0] res_slice_s;
  logic [WORD_W-1:0]  word_s;
  logic               last_s;
  logic               issue_s;
  logic               commit_s;

  // Operand fetch: r0 reads as zero, immediate replaces rhs when enabled.
  always_comb begin
    lhs_word_s = {WORD_W{1'b0}};
    rhs_word_s = {WORD_W{1'b0}};
    if (lhs_q == R0) begin
      lhs_word_s = {WORD_W{1'b0}};
    end else begin
      lhs_word_s = rf_q[lhs_q];
    end
    if (imm_en_q) begin
      rhs_word_s = imm_q;
    end else if (rhs_q == R0) begin
      rhs_word_s = {WORD_W{1'b0}};
    end else begin
      rhs_word_s = rf_q[rhs_q];
    end
  end

  // Slice ALU: carry enters from the carry flop except at beat 0 where cin is injected.
  always_comb begin
    a_s         = slice_of(lhs_word_s, ctr_q);
    b_s         = slice_of(rhs_word_s, ctr_q);
    is_sub_s    = (op_q == OP_SUB);
    is_arith_s  = (op_q == OP_ADD) || (op_q == OP_SUB);
    op_valid_s  = (op_q <= OP_MOV);
    b_add_s     = is_sub_s ? ~b_s : b_s;
    cin_s       = (ctr_q == FIRST_BEAT) ? is_sub_s : carry_q;
    sum_s       = {1'b0, a_s} + {1'b0, b_add_s} + {{SLICE_W{1'b0}}, cin_s};
    res_slice_s = {SLICE_W{1'b0}};
    case (op_q)
      OP_ADD:  res_slice_s = sum_s[SLICE_W-1:0];
      OP_SUB:  res_slice_s = sum_s[SLICE_W-1:0];
      OP_AND:  res_slice_s = a_s & b_s;
      OP_OR:   res_slice_s = a_s | b_s;
      OP_XOR:  res_slice_s = a_s ^ b_s;
      OP_MOV:  res_slice_s = b_s;
      default: res_slice_s = {SLICE_W{1'b0}};
    endcase
    word_s = {res_slice_s, shadow_q};
  end

  // Window events: issue sampling, commit qualification.
  always_comb begin
    last_s   = (ctr_q == LAST_BEAT);
    issue_s  = last_s && i_sx_vld;
    commit_s = busy_q && last_s && !cancel_q && !i_sx_flush && op_valid_s;
  end

  // Next-state logic for counter, window status, carry chain, shadow and flags.
  always_comb begin
    ctr_d    = ctr_q + CW'(1);
    carry_d  = sum_s[SLICE_W];
    shadow_d = word_s[WORD_W-1:SLICE_W];
    done_d   = commit_s;
    busy_d   = busy_q;
    cancel_d = cancel_q;
    z_d      = z_q;
    c_d      = c_q;
    if (last_s) begin
      // A new window starts: a same-cycle flush belongs to the old instruction.
      busy_d   = i_sx_vld;
      cancel_d = 1'b0;
    end else if (busy_q && i_sx_flush) begin
      cancel_d = 1'b1;
    end else begin
      cancel_d = cancel_q;
    end
    if (commit_s) begin
      z_d = (word_s == {WORD_W{1'b0}});
      c_d = is_arith_s && sum_s[SLICE_W];
    end else begin
      z_d = z_q;
      c_d = c_q;
    end
  end

  // Control and flag state register.
  always_ff @(posedge i_sx_gck) begin
    if (i_sx_rst) begin
      ctr_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      cancel_q <= 1'b0;
      carry_q  <= 1'b0;
      shadow_q <= {SHW{1'b0}};
      done_q   <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      ctr_q    <= ctr_d;
      busy_q   <= busy_d;
      cancel_q <= cancel_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      z_q      <= z_d;
      c_q      <= c_d;
    end
  end

  // Instruction field latch, loaded only on an accepted issue.
  always_ff @(posedge i_sx_gck) begin
    if (i_sx_rst) begin
      op_q     <= 3'd0;
      dst_q    <= {RW{1'b0}};
      lhs_q    <= {RW{1'b0}};
      rhs_q    <= {RW{1'b0}};
      imm_en_q <= 1'b0;
      imm_q    <= {WORD_W{1'b0}};
    end else if (issue_s) begin
      op_q     <= i_sx_op;
      dst_q    <= i_sx_dst;
      lhs_q    <= i_sx_lhs;
      rhs_q    <= i_sx_rhs;
      imm_en_q <= i_sx_imm_en;
      imm_q    <= i_sx_imm;
    end else begin
      op_q     <= op_q;
      dst_q    <= dst_q;
      lhs_q    <= lhs_q;
      rhs_q    <= rhs_q;
      imm_en_q <= imm_en_q;
      imm_q    <= imm_q;
    end
  end

  // Register file: whole-word atomic commit at window end, r0 writes dropped.
  always_ff @(posedge i_sx_gck) begin
    if (i_sx_rst) begin
      rf_q[0] <= {WORD_W{1'b0}};
    end else if (commit_s && (dst_q != R0)) begin
      rf_q[dst_q] <= word_s;
    end else begin
      rf_q[0] <= {WORD_W{1'b0}};
    end
  end

  // Output drive: result slice only while busy, validity drops on flush.
  always_comb begin
    o_sx_ctr     = ctr_q;
    o_sx_busy    = busy_q;
    o_sx_res     = busy_q ? res_slice_s : {SLICE_W{1'b0}};
    o_sx_res_vld = busy_q && !cancel_q && !i_sx_flush;
    o_sx_done    = done_q;
    o_sx_z       = z_q;
    o_sx_c       = c_q;
  end

endmodule

// File: tb/tb_idli_sx_m.sv
// Scoreboard bench for idli_sx_m (SLICE_W=4, WORD_W=16, NREG=16).
// Stimulus pushes hand-computed result slices and flag pairs; a negedge
// monitor pops and compares whenever the DUT shows res_vld or done.
module tb_idli_sx_m;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] MOV = 3'd5;
  localparam logic [2:0] RSV = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [2:0]  op;
  logic [3:0]  dst, lhs, rhs;
  logic        imm_en;
  logic [15:0] imm;
  logic        flush;
  logic [1:0]  ctr;
  logic        busy;
  logic [3:0]  res;
  logic        res_vld;
  logic        done;
  logic        z, c;

  int n_cmp = 0;
  int n_bad = 0;

  // {care, slice} per expected valid beat; {z, c} per expected done
  logic [4:0] exp_res [$];
  logic [1:0] exp_flg [$];

  idli_sx_m dut (
    .i_sx_gck    (clk),
    .i_sx_rst    (rst),
    .i_sx_vld    (vld),
    .i_sx_op     (op),
    .i_sx_dst    (dst),
    .i_sx_lhs    (lhs),
    .i_sx_rhs    (rhs),
    .i_sx_imm_en (imm_en),
    .i_sx_imm    (imm),
    .i_sx_flush  (flush),
    .o_sx_ctr    (ctr),
    .o_sx_busy   (busy),
    .o_sx_res    (res),
    .o_sx_res_vld(res_vld),
    .o_sx_done   (done),
    .o_sx_z      (z),
    .o_sx_c      (c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Push the first n slices (LSB first) of a hand-computed result word.
  task automatic push_res(input logic [15:0] w, input int n, input logic care);
    for (int k = 0; k < n; k++) begin
      exp_res.push_back({care, w[k*4 +: 4]});
    end
  endtask

  // Advance (from posedge+1 phase) until ctr equals v, bounded.
  task automatic wait_ctr(input logic [1:0] v);
    int guard = 0;
    while (ctr !== v && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("wait_ctr", 16'(ctr), 16'(v));
  endtask

  // Issue one instruction at the next ctr==3 beat; returns at ctr==0 (posedge+1).
  task automatic issue(input logic [2:0] o, input logic [3:0] d, input logic [3:0] l,
                       input logic [3:0] r, input logic ie, input logic [15:0] iv);
    wait_ctr(2'd3);
    vld = 1'b1; op = o; dst = d; lhs = l; rhs = r; imm_en = ie; imm = iv;
    @(posedge clk); #1;
    vld = 1'b0; op = 3'd0; dst = 4'd0; lhs = 4'd0; rhs = 4'd0; imm_en = 1'b0; imm = 16'h0000;
  endtask

  // Monitor: pop and compare whenever the DUT presents a slice or a done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_vld) begin
        if (exp_res.size() == 0) begin
          chk("res_unexpected", {12'h000, res}, 16'hFFFF);
        end else begin
          logic [4:0] e;
          e = exp_res.pop_front();
          if (e[4]) chk("res_slice", 16'(res), 16'(e[3:0]));
        end
      end
      if (done) begin
        if (exp_flg.size() == 0) begin
          chk("done_unexpected", 16'(done), 16'h0000);
        end else begin
          logic [1:0] f;
          f = exp_flg.pop_front();
          chk("flags_zc", 16'({z, c}), 16'(f));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_ctr [5];
    exp_ctr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; vld = 1'b0; op = 3'd0; dst = 4'd0; lhs = 4'd0; rhs = 4'd0;
    imm_en = 1'b0; imm = 16'h0000; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset: counter sequence, all outputs quiet, vld at ctr=1 ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_ctr", 16'(ctr), 16'(exp_ctr[i]));
      chk("reset_outs", {10'd0, busy, res_vld, done, z, c, 1'b0} | 16'(res), 16'h0000);
      if (i == 1) vld = 1'b1;
      if (i == 2) vld = 1'b0;
    end
    @(posedge clk); #1;

    // MOV r1,#0x1234 then ADD r2,r1,#0x0FFF back-to-back
    issue(MOV, 4'd1, 4'd0, 4'd0, 1'b1, 16'h1234);
    push_res(16'h1234, 4, 1'b1); exp_flg.push_back(2'b00);
    issue(ADD, 4'd2, 4'd1, 4'd0, 1'b1, 16'h0FFF);
    push_res(16'h2233, 4, 1'b1); exp_flg.push_back(2'b00);
    // Read back r2
    issue(MOV, 4'd7, 4'd0, 4'd2, 1'b0, 16'h0000);
    push_res(16'h2233, 4, 1'b1); exp_flg.push_back(2'b00);

    // SUB r3,r1,r1
    issue(SUB, 4'd3, 4'd1, 4'd1, 1'b0, 16'h0000);
    push_res(16'h0000, 4, 1'b1); exp_flg.push_back(2'b11);

    // Carry ripple
    issue(MOV, 4'd4, 4'd0, 4'd0, 1'b1, 16'hFFFF);
    push_res(16'hFFFF, 4, 1'b1); exp_flg.push_back(2'b00);
    issue(ADD, 4'd5, 4'd4, 4'd0, 1'b1, 16'h0001);
    push_res(16'h0000, 4, 1'b1); exp_flg.push_back(2'b11);

    // Flush at ctr=2: only beats 0,1 valid, no done
    issue(ADD, 4'd2, 4'd1, 4'd0, 1'b1, 16'h0001);
    push_res(16'h1235, 2, 1'b1);
    wait_ctr(2'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    issue(MOV, 4'd8, 4'd0, 4'd2, 1'b0, 16'h0000);
    push_res(16'h2233, 4, 1'b1); exp_flg.push_back(2'b00);
    chk("flush2_flags_done", 16'({z, c, done}), 16'h0006);

    // Flush at ctr=3 with a MOV issued in the same cycle
    issue(ADD, 4'd2, 4'd1, 4'd0, 1'b1, 16'h0001);
    push_res(16'h1235, 3, 1'b1);
    wait_ctr(2'd3);
    flush = 1'b1;
    issue(MOV, 4'd9, 4'd0, 4'd0, 1'b1, 16'hA5C3);
    flush = 1'b0;
    push_res(16'hA5C3, 4, 1'b1); exp_flg.push_back(2'b00);
    chk("flush3_busy", 16'(busy), 16'h0001);
    issue(MOV, 4'd10, 4'd0, 4'd2, 1'b0, 16'h0000);
    push_res(16'h2233, 4, 1'b1); exp_flg.push_back(2'b00);

    // r0: write discarded, flags and done still happen
    issue(MOV, 4'd0, 4'd0, 4'd0, 1'b1, 16'h00FF);
    push_res(16'h00FF, 4, 1'b1); exp_flg.push_back(2'b00);
    issue(MOV, 4'd6, 4'd0, 4'd0, 1'b0, 16'h0000);
    push_res(16'h0000, 4, 1'b1); exp_flg.push_back(2'b10);
    issue(MOV, 4'd11, 4'd0, 4'd6, 1'b0, 16'h0000);
    push_res(16'h0000, 4, 1'b1); exp_flg.push_back(2'b10);

    // Reserved op 7 targeting r5 (holds 0): no commit, no done
    issue(RSV, 4'd5, 4'd1, 4'd0, 1'b1, 16'h1111);
    push_res(16'h0000, 4, 1'b0);
    issue(MOV, 4'd12, 4'd0, 4'd5, 1'b0, 16'h0000);
    push_res(16'h0000, 4, 1'b1); exp_flg.push_back(2'b10);
    chk("rsv_no_done", 16'(done), 16'h0000);

    repeat (8) @(posedge clk);
    #1;
    chk("res_queue_drained", 16'(exp_res.size()), 16'h0000);
    chk("flag_queue_drained", 16'(exp_flg.size()), 16'h0000);
    chk("idle_busy", 16'(busy), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
